// File: rtl/egress_header_rewrite.sv
// Egress header rewrite: a one-deep register slice that decrements TTL, patches the IPv4
// checksum and source MAC, and redirects TTL-expired packets to the matching CPU port.
module egress_header_rewrite #(
  parameter int C_S_AXI_DATA_WIDTH   = 32,
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int DST_PORT_POS         = 24
) (
  input  logic                               AXI_ACLK,
  input  logic                               AXI_RESET,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]     S_AXIS_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]   S_AXIS_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]    S_AXIS_TUSER,
  input  logic                               S_AXIS_TVALID,
  output logic                               S_AXIS_TREADY,
  input  logic                               S_AXIS_TLAST,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]     M_AXIS_TDATA,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]    M_AXIS_TUSER,
  output logic                               M_AXIS_TVALID,
  input  logic                               M_AXIS_TREADY,
  output logic                               M_AXIS_TLAST,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]      stats_reset,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]      mac0_low,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]      mac0_high,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]      mac1_low,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]      mac1_high,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]      mac2_low,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]      mac2_high,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]      mac3_low,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]      mac3_high,
  output logic [C_S_AXI_DATA_WIDTH-1:0]      rewritten_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0]      ttl_expired_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0]      passthru_count
);
  localparam int CW = C_S_AXI_DATA_WIDTH;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic {ST_HDR, ST_BODY} state_e;

  state_e                            state_q, state_d;
  logic                              tvalid_q, tvalid_d;
  logic                              tlast_q, tlast_d;
  logic [C_M_AXIS_DATA_WIDTH-1:0]    tdata_q, tdata_d;
  logic [C_M_AXIS_DATA_WIDTH/8-1:0]  tstrb_q, tstrb_d;
  logic [C_M_AXIS_TUSER_WIDTH-1:0]   tuser_q, tuser_d;
  logic [CW-1:0]                     rew_cnt_q, rew_cnt_d;
  logic [CW-1:0]                     exp_cnt_q, exp_cnt_d;
  logic [CW-1:0]                     pass_cnt_q, pass_cnt_d;

  logic        s_fire, ip_ok, mac_hit, do_rewrite, do_expire;
  logic [1:0]  mac_sel;
  logic [47:0] port_mac;
  logic [7:0]  ttl, cpu_byte;
  logic [15:0] hc_new;
  logic [16:0] cksum_sum;
  logic        unused_mac_high;

  // Handshake: a beat moves on S when S_AXIS_TVALID && S_AXIS_TREADY and on M when
  // M_AXIS_TVALID && M_AXIS_TREADY; the slot accepts whenever it is empty or draining.
  assign S_AXIS_TREADY = !tvalid_q || M_AXIS_TREADY;
  assign s_fire        = S_AXIS_TVALID && S_AXIS_TREADY;

  assign ip_ok      = (S_AXIS_TDATA[159:144] == 16'h0800) && (S_AXIS_TDATA[143:136] == 8'h45);
  assign ttl        = S_AXIS_TDATA[79:72];
  assign do_rewrite = ip_ok && mac_hit && (ttl > 8'd1);
  assign do_expire  = ip_ok && mac_hit && (ttl <= 8'd1);
  assign cksum_sum  = {1'b0, S_AXIS_TDATA[63:48]} + 17'h00100;
  assign hc_new     = cksum_sum[15:0] + {15'd0, cksum_sum[16]};
  assign cpu_byte   = 8'b0000_0010 << {mac_sel, 1'b0};

  assign unused_mac_high = ^{mac0_high[31:16], mac1_high[31:16], mac2_high[31:16], mac3_high[31:16]};

  // Lowest-numbered MAC port wins when several MAC bits are set.
  always_comb begin
    mac_hit = 1'b0;
    mac_sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (S_AXIS_TUSER[DST_PORT_POS + 2*i]) begin
        mac_hit = 1'b1;
        mac_sel = 2'(i);
      end
    end
  end

  always_comb begin
    port_mac = {mac0_high[15:0], mac0_low};
    case (mac_sel)
      2'd1:    port_mac = {mac1_high[15:0], mac1_low};
      2'd2:    port_mac = {mac2_high[15:0], mac2_low};
      2'd3:    port_mac = {mac3_high[15:0], mac3_low};
      default: port_mac = {mac0_high[15:0], mac0_low};
    endcase
  end

  always_comb begin
    state_d    = state_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    tdata_d    = tdata_q;
    tstrb_d    = tstrb_q;
    tuser_d    = tuser_q;
    rew_cnt_d  = rew_cnt_q;
    exp_cnt_d  = exp_cnt_q;
    pass_cnt_d = pass_cnt_q;
    if (s_fire) begin
      tvalid_d = 1'b1;
      tlast_d  = S_AXIS_TLAST;
      tdata_d  = S_AXIS_TDATA;
      tstrb_d  = S_AXIS_TSTRB;
      tuser_d  = S_AXIS_TUSER;
      state_d  = S_AXIS_TLAST ? ST_HDR : ST_BODY;
      if (state_q == ST_HDR) begin
        if (do_rewrite) begin
          tdata_d[79:72]   = ttl - 8'd1;
          tdata_d[63:48]   = hc_new;
          tdata_d[207:160] = port_mac;
          rew_cnt_d        = rew_cnt_q + CNT_ONE;
        end else if (do_expire) begin
          tuser_d[DST_PORT_POS +: 8] = cpu_byte;
          exp_cnt_d                  = exp_cnt_q + CNT_ONE;
        end else begin
          pass_cnt_d = pass_cnt_q + CNT_ONE;
        end
      end
    end else if (M_AXIS_TREADY) begin
      tvalid_d = 1'b0;
    end
    if (stats_reset == CNT_ONE) begin
      rew_cnt_d  = '0;
      exp_cnt_d  = '0;
      pass_cnt_d = '0;
    end
  end

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_RESET) begin
      state_q    <= ST_HDR;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tdata_q    <= '0;
      tstrb_q    <= '0;
      tuser_q    <= '0;
      rew_cnt_q  <= '0;
      exp_cnt_q  <= '0;
      pass_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      tdata_q    <= tdata_d;
      tstrb_q    <= tstrb_d;
      tuser_q    <= tuser_d;
      rew_cnt_q  <= rew_cnt_d;
      exp_cnt_q  <= exp_cnt_d;
      pass_cnt_q <= pass_cnt_d;
    end
  end

  assign M_AXIS_TVALID     = tvalid_q;
  assign M_AXIS_TLAST      = tlast_q;
  assign M_AXIS_TDATA      = tdata_q;
  assign M_AXIS_TSTRB      = tstrb_q;
  assign M_AXIS_TUSER      = tuser_q;
  assign rewritten_count   = rew_cnt_q;
  assign ttl_expired_count = exp_cnt_q;
  assign passthru_count    = pass_cnt_q;
endmodule

// File: tb/tb_egress_header_rewrite.sv
// Bench for egress_header_rewrite: directed header cases plus randomized packets, all
// output beats scored against a packet-level reference model.
module tb_egress_header_rewrite;
  localparam int DP = 24;
  localparam int VW = 417;

  logic         clk = 1'b0;
  logic         AXI_RESET;
  logic [255:0] S_AXIS_TDATA;
  logic [31:0]  S_AXIS_TSTRB;
  logic [127:0] S_AXIS_TUSER;
  logic         S_AXIS_TVALID, S_AXIS_TREADY, S_AXIS_TLAST;
  logic [255:0] M_AXIS_TDATA;
  logic [31:0]  M_AXIS_TSTRB;
  logic [127:0] M_AXIS_TUSER;
  logic         M_AXIS_TVALID, M_AXIS_TREADY, M_AXIS_TLAST;
  logic [31:0]  stats_reset;
  logic [31:0]  mac_low[4];
  logic [31:0]  mac_high[4];
  logic [31:0]  rewritten_count, ttl_expired_count, passthru_count;

  egress_header_rewrite dut (
    .AXI_ACLK(clk), .AXI_RESET(AXI_RESET),
    .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TSTRB(S_AXIS_TSTRB), .S_AXIS_TUSER(S_AXIS_TUSER),
    .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TREADY(S_AXIS_TREADY), .S_AXIS_TLAST(S_AXIS_TLAST),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TSTRB(M_AXIS_TSTRB), .M_AXIS_TUSER(M_AXIS_TUSER),
    .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY), .M_AXIS_TLAST(M_AXIS_TLAST),
    .stats_reset(stats_reset),
    .mac0_low(mac_low[0]), .mac0_high(mac_high[0]), .mac1_low(mac_low[1]), .mac1_high(mac_high[1]),
    .mac2_low(mac_low[2]), .mac2_high(mac_high[2]), .mac3_low(mac_low[3]), .mac3_high(mac_high[3]),
    .rewritten_count(rewritten_count), .ttl_expired_count(ttl_expired_count),
    .passthru_count(passthru_count)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [VW-1:0] exp_q[$];
  logic [31:0]   m_rew = 0, m_exp = 0, m_pass = 0;
  int            in_idx = 0, out_idx = 0;
  logic          hold_v = 1'b0;
  logic [VW-1:0] hold_vec;
  logic [255:0]  last_hdr_data;
  logic [127:0]  last_hdr_user;
  int            rdy_mode = 0;

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  // ---------------- reference model ----------------
  // cls: 0 body beat, 1 rewritten, 2 ttl-expired, 3 passthrough
  function automatic logic [VW-1:0] model_beat(input logic [255:0] d, input logic [127:0] u,
                                               input logic [31:0] s, input logic l, input bit hdr,
                                               output int cls);
    logic [255:0] od;
    logic [127:0] ou;
    int sel, sum;
    od = d;
    ou = u;
    sel = -1;
    cls = 0;
    if (hdr) begin
      for (int i = 0; i < 4; i++) if (sel < 0 && u[DP + 2*i]) sel = i;
      if (d[159:144] == 16'h0800 && d[143:136] == 8'h45 && sel >= 0) begin
        if (d[79:72] > 8'd1) begin
          od[79:72] = d[79:72] - 8'd1;
          sum = int'(d[63:48]) + 256;
          if (sum > 65535) sum = sum - 65535;
          od[63:48] = sum[15:0];
          od[207:160] = {mac_high[sel][15:0], mac_low[sel]};
          cls = 1;
        end else begin
          for (int b = 0; b < 8; b++) ou[DP + b] = (b == 2*sel + 1);
          cls = 2;
        end
      end else begin
        cls = 3;
      end
    end
    return {od, ou, s, l};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  wire [VW-1:0] out_vec = {M_AXIS_TDATA, M_AXIS_TUSER, M_AXIS_TSTRB, M_AXIS_TLAST};

  always @(negedge clk) begin : mon
    int cls;
    logic [VW-1:0] e;
    if (AXI_RESET) begin
      exp_q.delete();
      in_idx = 0;
      out_idx = 0;
      hold_v = 1'b0;
      m_rew = 0; m_exp = 0; m_pass = 0;
    end else begin
      chk("s_tready_rule", S_AXIS_TREADY, !M_AXIS_TVALID || M_AXIS_TREADY);
      if (hold_v) begin
        chk("hold_valid", M_AXIS_TVALID, 1'b1);
        chk("hold_stable", out_vec, hold_vec);
      end
      hold_v = M_AXIS_TVALID && !M_AXIS_TREADY;
      hold_vec = out_vec;
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL out_beat: unexpected beat %0h", out_vec);
        end else begin
          e = exp_q.pop_front();
          chk("out_beat", out_vec, e);
        end
        if (out_idx == 0) begin
          last_hdr_data = M_AXIS_TDATA;
          last_hdr_user = M_AXIS_TUSER;
        end
        out_idx = M_AXIS_TLAST ? 0 : out_idx + 1;
      end
      if (S_AXIS_TVALID && S_AXIS_TREADY) begin
        e = model_beat(S_AXIS_TDATA, S_AXIS_TUSER, S_AXIS_TSTRB, S_AXIS_TLAST, in_idx == 0, cls);
        exp_q.push_back(e);
        if (cls == 1) m_rew = m_rew + 1;
        if (cls == 2) m_exp = m_exp + 1;
        if (cls == 3) m_pass = m_pass + 1;
        in_idx = S_AXIS_TLAST ? 0 : in_idx + 1;
      end
      if (stats_reset == 32'd1) begin
        m_rew = 0; m_exp = 0; m_pass = 0;
      end
    end
  end

  // ---------------- output ready driver ----------------
  initial begin
    M_AXIS_TREADY = 1'b1;
    forever begin
      @(posedge clk); #2;
      case (rdy_mode)
        0:       M_AXIS_TREADY = 1'b1;
        1:       M_AXIS_TREADY = 1'b0;
        default: M_AXIS_TREADY = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // ---------------- input driver ----------------
  logic [255:0] pkt_d[8];
  logic [127:0] pkt_u;

  task automatic rand_fill(input int len);
    for (int i = 0; i < len; i++)
      for (int w = 0; w < 8; w++) pkt_d[i][32*w +: 32] = $urandom();
  endtask

  task automatic set_hdr(input logic [15:0] eth, input logic [7:0] vi, input logic [7:0] ttl,
                         input logic [15:0] hc);
    pkt_d[0][159:144] = eth;
    pkt_d[0][143:136] = vi;
    pkt_d[0][79:72]   = ttl;
    pkt_d[0][63:48]   = hc;
  endtask

  // Called at posedge+1; returns at posedge+1 right after the beat is accepted.
  task automatic drive_beat(input logic [255:0] d, input logic [127:0] u, input logic l);
    int waited;
    waited = 0;
    S_AXIS_TVALID = 1'b1;
    S_AXIS_TDATA  = d;
    S_AXIS_TUSER  = u;
    S_AXIS_TSTRB  = $urandom();
    S_AXIS_TLAST  = l;
    @(negedge clk);
    while (!S_AXIS_TREADY && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) timeout_fail("s_accept");
    @(posedge clk); #1;
    S_AXIS_TVALID = 1'b0;
  endtask

  task automatic send_pkt(input int len, input int max_gap);
    for (int i = 0; i < len; i++) begin
      repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1; end
      drive_beat(pkt_d[i], pkt_u, i == len - 1);
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    rdy_mode = 0;
    while ((exp_q.size() != 0 || M_AXIS_TVALID) && w < 500) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 500) timeout_fail("drain");
  endtask

  task automatic stats_pulse();
    stats_reset = 32'd1;
    @(posedge clk); #1;
    stats_reset = 32'd0;
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_rew"},  rewritten_count,   m_rew);
    chk({tag, "_exp"},  ttl_expired_count, m_exp);
    chk({tag, "_pass"}, passthru_count,    m_pass);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int c0, len, r;
    logic [15:0] eth, hc;
    logic [7:0]  vi, ttl, db;
    AXI_RESET = 1'b1;
    S_AXIS_TVALID = 1'b0; S_AXIS_TDATA = '0; S_AXIS_TUSER = '0; S_AXIS_TSTRB = '0;
    S_AXIS_TLAST = 1'b0; stats_reset = 32'd0;
    for (int i = 0; i < 4; i++) begin
      mac_low[i]  = $urandom();
      mac_high[i] = $urandom();
    end
    mac_low[1]  = 32'h2233_4455;
    mac_high[1] = 32'hABCD_0011;
    repeat (3) @(posedge clk);
    #1 AXI_RESET = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_tvalid", M_AXIS_TVALID, 1'b0);
    chk("rst_tdata", M_AXIS_TDATA, 256'd0);
    chk("rst_tuser", M_AXIS_TUSER, 128'd0);
    chk("rst_tstrb_tlast", {M_AXIS_TSTRB, M_AXIS_TLAST}, 33'd0);
    chk("rst_counts", {rewritten_count, ttl_expired_count, passthru_count}, 96'd0);
    @(posedge clk); #1;

    // IPv4 rewrite on MAC1, single beat, latency 1
    rand_fill(1);
    set_hdr(16'h0800, 8'h45, 8'h40, 16'hB861);
    pkt_u = '0; pkt_u[26] = 1'b1;
    S_AXIS_TVALID = 1'b1; S_AXIS_TDATA = pkt_d[0]; S_AXIS_TUSER = pkt_u;
    S_AXIS_TSTRB = 32'hFFFF_FFFF; S_AXIS_TLAST = 1'b1;
    @(negedge clk);
    chk("lat_pre_valid", M_AXIS_TVALID, 1'b0);
    @(posedge clk); #1;
    S_AXIS_TVALID = 1'b0;
    @(negedge clk);
    chk("lat_valid", M_AXIS_TVALID, 1'b1);
    chk("t1_ttl", M_AXIS_TDATA[79:72], 8'h3F);
    chk("t1_hc", M_AXIS_TDATA[63:48], 16'hB961);
    chk("t1_src_mac", M_AXIS_TDATA[207:160], 48'h0011_2233_4455);
    @(posedge clk); #1;
    drain();
    chk("t1_rew_cnt", rewritten_count, 32'd1);

    // checksum end-around carry
    stats_pulse();
    rand_fill(1);
    set_hdr(16'h0800, 8'h45, 8'h05, 16'hFF00);
    pkt_u = '0; pkt_u[24] = 1'b1;
    send_pkt(1, 0);
    drain();
    chk("t2_hc_wrap", last_hdr_data[63:48], 16'h0001);
    chk("t2_ttl", last_hdr_data[79:72], 8'h04);

    // TTL expiry to CPU port of MAC2, 3 beats
    stats_pulse();
    rand_fill(3);
    set_hdr(16'h0800, 8'h45, 8'h01, $urandom_range(0, 65535));
    pkt_u = {$urandom(), $urandom(), $urandom(), $urandom()};
    pkt_u[31:24] = 8'b0001_0000;
    send_pkt(3, 1);
    drain();
    chk("t3_data_same", last_hdr_data, pkt_d[0]);
    chk("t3_dst_byte", last_hdr_user[31:24], 8'b0010_0000);
    chk("t3_exp_cnt", ttl_expired_count, 32'd1);

    // ARP (4 beats) then IPv4 (3 beats), back to back at full rate
    stats_pulse();
    c0 = cyc;
    rand_fill(4);
    set_hdr(16'h0806, 8'h45, 8'h40, 16'h1234);
    pkt_u = '0; pkt_u[30] = 1'b1;
    send_pkt(4, 0);
    rand_fill(3);
    set_hdr(16'h0800, 8'h45, 8'h80, 16'h4321);
    pkt_u = '0; pkt_u[30] = 1'b1;
    send_pkt(3, 0);
    chk("t4_throughput", cyc - c0, 7);
    drain();
    chk("t4_pass_cnt", passthru_count, 32'd1);
    chk("t4_rew_cnt", rewritten_count, 32'd1);

    // output stall for 5 cycles mid-packet
    rand_fill(6);
    set_hdr(16'h0800, 8'h45, 8'h22, 16'hAAAA);
    pkt_u = '0; pkt_u[28] = 1'b1;
    fork
      send_pkt(6, 0);
      begin
        repeat (2) @(posedge clk);
        #1 rdy_mode = 1;
        @(negedge clk); @(negedge clk);
        chk("stall_mvalid", M_AXIS_TVALID, 1'b1);
        chk("stall_sready", S_AXIS_TREADY, 1'b0);
        repeat (3) @(posedge clk);
        #1 rdy_mode = 0;
      end
    join
    drain();
    check_counters("t5");

    // reset during BODY, then a fresh IPv4 packet
    rand_fill(5);
    set_hdr(16'h0800, 8'h45, 8'h33, 16'h0F0F);
    pkt_u = '0; pkt_u[24] = 1'b1;
    drive_beat(pkt_d[0], pkt_u, 1'b0);
    drive_beat(pkt_d[1], pkt_u, 1'b0);
    AXI_RESET = 1'b1;
    repeat (2) @(posedge clk);
    #1 AXI_RESET = 1'b0;
    @(negedge clk);
    chk("t6_out_zero", {M_AXIS_TVALID, out_vec}, {1'b0, 417'd0});
    chk("t6_cnt_zero", {rewritten_count, ttl_expired_count, passthru_count}, 96'd0);
    @(posedge clk); #1;
    rand_fill(2);
    set_hdr(16'h0800, 8'h45, 8'h10, 16'h2000);
    pkt_u = '0; pkt_u[26] = 1'b1;
    send_pkt(2, 0);
    drain();
    chk("t6_ttl", last_hdr_data[79:72], 8'h0F);
    chk("t6_rew_cnt", rewritten_count, 32'd1);

    // stats_reset concurrent with an increment
    rand_fill(1);
    set_hdr(16'h0800, 8'h45, 8'h10, 16'h2000);
    stats_reset = 32'd1;
    drive_beat(pkt_d[0], pkt_u, 1'b1);
    stats_reset = 32'd0;
    drain();
    chk("t7_stats_prio", rewritten_count, 32'd0);

    // randomized packets with random gaps and backpressure
    rdy_mode = 2;
    for (int p = 0; p < 150; p++) begin
      len = $urandom_range(1, 5);
      rand_fill(len);
      r = $urandom_range(0, 9);
      eth = (r < 7) ? 16'h0800 : ((r == 7) ? 16'h0806 : 16'h86DD);
      vi  = ($urandom_range(0, 7) == 0) ? 8'h46 : 8'h45;
      case ($urandom_range(0, 3))
        0:       ttl = 8'd0;
        1:       ttl = 8'd1;
        2:       ttl = 8'd2;
        default: ttl = 8'($urandom_range(0, 255));
      endcase
      hc = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 3) == 0) hc[15:8] = 8'hFF;
      set_hdr(eth, vi, ttl, hc);
      pkt_u = {$urandom(), $urandom(), $urandom(), $urandom()};
      db = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) db = db & 8'hAA;
      pkt_u[31:24] = db;
      send_pkt(len, 2);
      rdy_mode = 2;
    end
    drain();
    check_counters("rand");
    chk("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
